// File: rtl/fifo_burst_reader.sv
// rtl/fifo_burst_reader.sv - reads fixed-length bursts from a FIFO into a ready/valid stream.
// Optional idle-timeout partial bursts are enabled by defining BURST_TIMEOUT_EN.
module fifo_burst_reader #(
  parameter int DWIDTH  = 16,
  parameter int AWIDTH  = 4,
  parameter int BURST   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fifo_empty,
  input  logic [AWIDTH:0]   fifo_num,
  input  logic [DWIDTH-1:0] fifo_data,
  output logic              fifo_pop,
  input  logic              flush,
  output logic [DWIDTH-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic              busy
);

  localparam int CW = $clog2(BURST + 1);
  localparam logic [AWIDTH:0] BURST_N = (AWIDTH + 1)'(BURST);

  typedef enum logic {S_IDLE, S_BURST} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     len_q, len_d;
  logic [CW-1:0]     pops_left_q, pops_left_d;
  logic [CW-1:0]     beats_q, beats_d;
  logic              inflight_q, inflight_d;
  logic [DWIDTH-1:0] buf_q [0:1];
  logic [DWIDTH-1:0] buf_d [0:1];
  logic              rd_ptr_q, rd_ptr_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic [1:0]        occ_q, occ_d;

  logic              xfer;
  logic              is_last;
  logic              trigger;
  logic              timeout_fire;
  logic [1:0]        occ_eff;
  logic [CW-1:0]     len_n;

  assign m_valid = (occ_q != 2'd0);
  assign m_data  = buf_q[rd_ptr_q];
  assign busy    = (state_q != S_IDLE);
  assign xfer    = m_valid && m_ready;
  assign is_last = (beats_q == len_q - CW'(1));
  assign m_last  = m_valid && (state_q == S_BURST) && is_last;
  // A beat leaving this cycle frees its slot, which keeps back-to-back pops going.
  assign occ_eff = occ_q - {1'b0, xfer};
  assign len_n   = (fifo_num >= BURST_N) ? CW'(BURST) : CW'(fifo_num);

`ifdef BURST_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 2);
  logic [TW-1:0] timer_q, timer_d;

  always_comb begin
    timer_d = '0;
    if (state_q == S_IDLE && !fifo_empty && fifo_num < BURST_N) begin
      timer_d = (timer_q == TW'(TIMEOUT)) ? timer_q : timer_q + TW'(1);
    end
  end

  assign timeout_fire = (state_q == S_IDLE) && (timer_q == TW'(TIMEOUT));

  always_ff @(posedge clk) begin
    if (reset) timer_q <= '0;
    else       timer_q <= timer_d;
  end
`else
  assign timeout_fire = 1'b0;
`endif

  assign trigger = (fifo_num != '0) &&
                   ((fifo_num >= BURST_N) || (flush && !fifo_empty) || timeout_fire);

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    pops_left_d = pops_left_q;
    beats_d     = beats_q;
    inflight_d  = 1'b0;
    buf_d       = buf_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    fifo_pop    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (trigger) begin
          state_d     = S_BURST;
          len_d       = len_n;
          pops_left_d = len_n;
          beats_d     = '0;
        end
      end
      S_BURST: begin
        if (pops_left_q != '0 && !fifo_empty && (occ_eff + {1'b0, inflight_q}) < 2'd2) begin
          fifo_pop    = 1'b1;
          pops_left_d = pops_left_q - CW'(1);
        end
        if (xfer) begin
          if (is_last) begin
            state_d = S_IDLE;
            beats_d = '0;
          end else begin
            beats_d = beats_q + CW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    inflight_d = fifo_pop;
    if (inflight_q) begin
      buf_d[wr_ptr_q] = fifo_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (xfer) rd_ptr_d = ~rd_ptr_q;
    occ_d = occ_q + {1'b0, inflight_q} - {1'b0, xfer};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      pops_left_q <= '0;
      beats_q     <= '0;
      inflight_q  <= 1'b0;
      buf_q[0]    <= '0;
      buf_q[1]    <= '0;
      rd_ptr_q    <= 1'b0;
      wr_ptr_q    <= 1'b0;
      occ_q       <= 2'd0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      pops_left_q <= pops_left_d;
      beats_q     <= beats_d;
      inflight_q  <= inflight_d;
      buf_q[0]    <= buf_d[0];
      buf_q[1]    <= buf_d[1];
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      occ_q       <= occ_d;
    end
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb/tb_fifo_burst_reader.sv - scoreboard bench for fifo_burst_reader with a FIFO model.
module tb_fifo_burst_reader;

  localparam int BURST = 4;

  typedef struct {
    logic [15:0] d;
    logic        l;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        fifo_empty;
  logic [4:0]  fifo_num;
  logic [15:0] fifo_data;
  logic        fifo_pop;
  logic        flush;
  logic [15:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic        m_last;
  logic        busy;

  fifo_burst_reader #(.DWIDTH(16), .AWIDTH(4), .BURST(BURST), .TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .fifo_empty(fifo_empty), .fifo_num(fifo_num),
    .fifo_data(fifo_data), .fifo_pop(fifo_pop), .flush(flush), .m_data(m_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last), .busy(busy)
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          errors  = 0;
  int          cyc     = 0;
  int          n_xfer  = 0;
  int          busy_fall = -1;
  int          xfer_cyc [$];
  logic [15:0] fq [$];
  logic [15:0] un_q [$];
  exp_t        exp_q [$];
  int          rmode = 0;
  int          ridx  = 0;
  logic [5:0]  rpat  = 6'b101001;
  logic        pop_seen = 1'b0;

  task automatic chk(input string name, input int act, input int expv);
    vectors++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // FIFO model and ready driver: updates land 1 time unit after the edge.
  always @(negedge clk) pop_seen = fifo_pop;
  always @(posedge clk) begin
    #1;
    if (pop_seen && fq.size() > 0) fifo_data = fq.pop_front();
    fifo_num   = 5'(fq.size());
    fifo_empty = (fq.size() == 0);
    case (rmode)
      0: m_ready = 1'b1;
      1: begin m_ready = rpat[ridx]; ridx = (ridx + 1) % 6; end
      2: m_ready = 1'($urandom);
      default: m_ready = 1'b0;
    endcase
  end

  // Reference model: the stream is the write order, cut into groups of BURST,
  // with a flush or timeout cutting whatever is left over.
  task automatic emit(input int n);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      e.d = un_q.pop_front();
      e.l = (i == n - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic predict();
    while (un_q.size() >= BURST) emit(BURST);
  endtask

  task automatic predict_flush();
    if (un_q.size() > 0) emit((un_q.size() < BURST) ? un_q.size() : BURST);
  endtask

  task automatic push_word(input logic [15:0] d);
    fq.push_back(d);
    un_q.push_back(d);
    fifo_num   = 5'(fq.size());
    fifo_empty = 1'b0;
    predict();
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while ((exp_q.size() != 0 || busy) && k < budget) begin
      @(posedge clk); #2;
      k++;
    end
    if (k >= budget) chk("drain_timeout", exp_q.size(), 0);
    repeat (2) begin @(posedge clk); #2; end
  endtask

  task automatic pulse_flush();
    predict_flush();
    flush = 1'b1;
    @(posedge clk); #2;
    flush = 1'b0;
  endtask

  // Monitor: scoreboard, stability under backpressure, pop legality.
  int   pops_tot = 0;
  int   xf_tot   = 0;
  logic prev_stall = 1'b0;
  logic [15:0] prev_d;
  logic prev_l;
  logic busy_prev = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      pops_tot   = 0;
      xf_tot     = 0;
      prev_stall = 1'b0;
      busy_prev  = 1'b0;
    end else begin
      int xf;
      xf = (m_valid && m_ready) ? 1 : 0;
      if (fifo_pop) begin
        chk("pop_nonempty", int'(fifo_empty), 0);
        chk("pop_window", int'((pops_tot - xf_tot - xf) < 2), 1);
        pops_tot++;
      end
      if (prev_stall) begin
        chk("stall_valid", int'(m_valid), 1);
        chk("stall_data", int'(m_data), int'(prev_d));
        chk("stall_last", int'(m_last), int'(prev_l));
      end
      if (xf == 1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", int'(m_data), -1);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("beat_data", int'(m_data), int'(e.d));
          chk("beat_last", int'(m_last), int'(e.l));
        end
        xfer_cyc.push_back(cyc);
        n_xfer++;
        xf_tot++;
      end
      prev_stall = m_valid && !m_ready;
      prev_d     = m_data;
      prev_l     = m_last;
      if (busy_prev && !busy) busy_fall = cyc;
      busy_prev = busy;
    end
  end

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    int c, base, f;
    reset = 1'b1; flush = 1'b0; m_ready = 1'b0;
    fifo_empty = 1'b1; fifo_num = '0; fifo_data = '0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_m_valid", int'(m_valid), 0);
    chk("rst_m_last", int'(m_last), 0);
    chk("rst_m_data", int'(m_data), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_fifo_pop", int'(fifo_pop), 0);
    reset = 1'b0;
    repeat (3) begin @(posedge clk); #2; end

    // Single burst of four, full throughput.
    c = cyc; base = n_xfer;
    for (int i = 0; i < 4; i++) push_word(16'hA0 + 16'(i));
    drain(200);
    chk("t1_count", n_xfer - base, 4);
    for (int i = 0; i < 4; i++)
      if (base + i < n_xfer) chk("t1_beat_cycle", xfer_cyc[base + i], c + 3 + i);
    chk("t1_busy_fall", busy_fall, c + 7);

    // Eight words become two back-to-back bursts.
    c = cyc; base = n_xfer;
    for (int i = 0; i < 8; i++) push_word(16'h10 + 16'(i));
    drain(200);
    chk("t2_count", n_xfer - base, 8);
    for (int i = 0; i < 8; i++)
      if (base + i < n_xfer) chk("t2_beat_cycle", xfer_cyc[base + i], c + 3 + i + ((i >= 4) ? 3 : 0));
    chk("t2_busy_fall", busy_fall, c + 14);

    // Backpressure pattern.
    rmode = 1; ridx = 0;
    base = n_xfer;
    for (int i = 0; i < 4; i++) push_word(16'hB0 + 16'(i));
    drain(400);
    chk("t3_count", n_xfer - base, 4);
    rmode = 0;
    repeat (2) begin @(posedge clk); #2; end

    // Partial burst via flush.
    base = n_xfer;
    push_word(16'hC0);
    push_word(16'hC1);
`ifndef BURST_TIMEOUT_EN
    repeat (100) begin @(posedge clk); #2; end
    chk("t4_no_output", n_xfer - base, 0);
`else
    repeat (2) begin @(posedge clk); #2; end
`endif
    f = cyc;
    pulse_flush();
    drain(200);
    chk("t4_count", n_xfer - base, 2);
    if (base + 1 < n_xfer) begin
      chk("t4_first_cycle", xfer_cyc[base], f + 3);
      chk("t4_second_cycle", xfer_cyc[base + 1], f + 4);
    end

`ifdef BURST_TIMEOUT_EN
    // Single word sent after the idle timeout.
    c = cyc; base = n_xfer;
    push_word(16'hD0);
    predict_flush();
    drain(400);
    chk("t5_count", n_xfer - base, 1);
    if (base < n_xfer) chk("t5_beat_cycle", xfer_cyc[base], c + 18);
`endif

    // Reset in the cycle after the second beat of a burst.
    rmode = 0;
    c = cyc; base = n_xfer;
    for (int i = 0; i < 4; i++) push_word(16'hE0 + 16'(i));
    repeat (4) @(posedge clk);
    #2;
    rmode = 3;
    @(posedge clk); #2;
    reset = 1'b1;
    fq.delete();
    fifo_num = '0;
    fifo_empty = 1'b1;
    @(posedge clk); #2;
    reset = 1'b0;
    @(negedge clk);
    chk("t6_beats_before_reset", n_xfer - base, 2);
    chk("t6_m_valid", int'(m_valid), 0);
    chk("t6_fifo_pop", int'(fifo_pop), 0);
    chk("t6_busy", int'(busy), 0);
    exp_q.delete();
    un_q.delete();
    @(posedge clk); #2;
    repeat (3) begin @(posedge clk); #2; end
    chk("t6_idle_after", int'(busy), 0);

    // Randomized rounds against the reference model.
    rmode = 2;
    for (int r = 0; r < 40; r++) begin
      int k;
      k = $urandom_range(1, 6);
      for (int j = 0; j < k; j++) begin
        push_word(16'($urandom));
        if ($urandom_range(0, 1) == 1) begin @(posedge clk); #2; end
      end
      drain(2000);
`ifdef BURST_TIMEOUT_EN
      if (un_q.size() > 0) begin pulse_flush(); drain(2000); end
`else
      if (un_q.size() > 0 && $urandom_range(0, 1) == 1) begin pulse_flush(); drain(2000); end
`endif
    end
    drain(2000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
